// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg: shared definitions for the load/store unit.
//   - FSM state encoding (IDLE/REQ/DONE)
//   - 3-bit memory op index derived from the one-hot op flags
//   - default timeout and counter width
package core_lsu_pkg;

   localparam int XLEN_DEF        = 32;
   localparam int TIMEOUT_CYC_DEF = 16;
   localparam int CNT_W           = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Index order matches the flag vector {i_sw,i_sh,i_sb,i_lhu,i_lbu,i_lw,i_lh,i_lb}.
   typedef enum logic [2:0] {
      OP_LB  = 3'd0,
      OP_LH  = 3'd1,
      OP_LW  = 3'd2,
      OP_LBU = 3'd3,
      OP_LHU = 3'd4,
      OP_SB  = 3'd5,
      OP_SH  = 3'd6,
      OP_SW  = 3'd7
   } lsu_op_e;

   // Only meaningful when exactly one flag is set; the caller checks that separately.
   function automatic lsu_op_e op_encode(input logic [7:0] flags);
      lsu_op_e op;
      op = OP_LB;
      for (int i = 0; i < 8; i++) begin
         if (flags[i]) op = lsu_op_e'(i[2:0]);
      end
      return op;
   endfunction

   function automatic logic op_is_store(input lsu_op_e op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/core_lsu_align.sv
// core_lsu_align: purely combinational data alignment for the LSU.
//   op_i        memory op index
//   addr_lo_i   effective address bits [1:0]
//   sdata_i     raw store data (RS2)
//   rdata_i     raw word read from memory
//   misalign_o  access is not naturally aligned for its size
//   store_o     op is a store
//   wstrb_o     byte enables (0 for loads)
//   wdata_o     store data replicated across all lanes
//   load_o      selected byte/half/word, sign- or zero-extended
module core_lsu_align
   import core_lsu_pkg::*;
(
   input  lsu_op_e     op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] sdata_i,
   input  logic [31:0] rdata_i,
   output logic        misalign_o,
   output logic        store_o,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_o
);

   logic [31:0] rshift;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign store_o = op_is_store(op_i);

   always_comb begin
      misalign_o = 1'b0;
      case (op_i)
         OP_LH, OP_LHU, OP_SH: misalign_o = addr_lo_i[0];
         OP_LW, OP_SW:         misalign_o = |addr_lo_i;
         default:              misalign_o = 1'b0;
      endcase
   end

   always_comb begin
      wstrb_o = 4'b0000;
      wdata_o = 32'h0;
      case (op_i)
         OP_SB: begin
            wstrb_o = 4'b0001 << addr_lo_i;
            wdata_o = {4{sdata_i[7:0]}};
         end
         OP_SH: begin
            wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{sdata_i[15:0]}};
         end
         OP_SW: begin
            wstrb_o = 4'b1111;
            wdata_o = sdata_i;
         end
         default: begin
            wstrb_o = 4'b0000;
            wdata_o = 32'h0;
         end
      endcase
   end

   // Byte lane picked by shifting the word down by 8*addr[1:0].
   assign rshift = rdata_i >> {addr_lo_i, 3'b000};
   assign rbyte  = rshift[7:0];
   assign rhalf  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      load_o = 32'h0;
      case (op_i)
         OP_LB:   load_o = {{24{rbyte[7]}}, rbyte};
         OP_LBU:  load_o = {24'h0, rbyte};
         OP_LH:   load_o = {{16{rhalf[15]}}, rhalf};
         OP_LHU:  load_o = {16'h0, rhalf};
         OP_LW:   load_o = rdata_i;
         default: load_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/core_lsu.sv
// core_lsu: load/store unit downstream of the ALU. Runs one data-memory
// transaction per accepted start over a req/ack handshake.
//   clk, rst_n                 clock, async active-low reset
//   start, i_lb..i_sw          issue pulse and one-hot op flags
//   addr, store_data           effective address and RS2
//   busy, done                 in-flight indication and completion pulse
//   load_data                  formatted load result (held until next accept)
//   fault_misalign, fault_bus  completion status
//   mem_req/we/addr/wdata/wstrb, mem_rdata, mem_ack   data bus
//
// state   | meaning
// IDLE    | waiting for a start with exactly one op flag
// REQ     | mem_req high, waiting for mem_ack or timeout
// DONE    | done pulse, results valid, back to IDLE next cycle
module core_lsu
   import core_lsu_pkg::*;
#(
   parameter int XLEN        = XLEN_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            i_lb,
   input  logic            i_lh,
   input  logic            i_lw,
   input  logic            i_lbu,
   input  logic            i_lhu,
   input  logic            i_sb,
   input  logic            i_sh,
   input  logic            i_sw,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] store_data,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] load_data,
   output logic            fault_misalign,
   output logic            fault_bus,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_wstrb,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack
);

   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

   logic [1:0]       state_q, state_d;
   lsu_op_e          op_q, op_d;
   logic [XLEN-1:0]  addr_q, addr_d;
   logic [XLEN-1:0]  sd_q, sd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  load_q, load_d;
   logic             fmis_q, fmis_d;
   logic             fbus_q, fbus_d;

   logic [7:0]  flags;
   logic        op_ok;
   lsu_op_e     op_in;
   logic        in_idle;
   lsu_op_e     al_op;
   logic [1:0]  al_addr_lo;
   logic        al_misalign;
   logic        al_store;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata;
   logic [31:0] al_load;

   assign flags = {i_sw, i_sh, i_sb, i_lhu, i_lbu, i_lw, i_lh, i_lb};
   assign op_ok = $onehot(flags);
   assign op_in = op_encode(flags);

   // In IDLE the aligner looks at the incoming op so misalignment is known
   // at accept time; afterwards it works from the latched op/address.
   assign in_idle    = (state_q == ST_IDLE);
   assign al_op      = in_idle ? op_in : op_q;
   assign al_addr_lo = in_idle ? addr[1:0] : addr_q[1:0];

   core_lsu_align u_align (
      .op_i       (al_op),
      .addr_lo_i  (al_addr_lo),
      .sdata_i    (sd_q),
      .rdata_i    (mem_rdata),
      .misalign_o (al_misalign),
      .store_o    (al_store),
      .wstrb_o    (al_wstrb),
      .wdata_o    (al_wdata),
      .load_o     (al_load)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      sd_d    = sd_q;
      cnt_d   = cnt_q;
      load_d  = load_q;
      fmis_d  = fmis_q;
      fbus_d  = fbus_q;
      case (state_q)
         ST_IDLE: begin
            if (start && op_ok) begin
               op_d   = op_in;
               addr_d = addr;
               sd_d   = store_data;
               cnt_d  = '0;
               load_d = '0;
               fmis_d = 1'b0;
               fbus_d = 1'b0;
               if (al_misalign) begin
                  fmis_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            cnt_d = cnt_q + 1'b1;
            // Ack has priority over a timeout landing in the same cycle.
            if (mem_ack) begin
               if (!al_store) load_d = al_load;
               state_d = ST_DONE;
            end else if (cnt_d == TO_LIM) begin
               fbus_d  = 1'b1;
               load_d  = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_LB;
         addr_q  <= '0;
         sd_q    <= '0;
         cnt_q   <= '0;
         load_q  <= '0;
         fmis_q  <= 1'b0;
         fbus_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         sd_q    <= sd_d;
         cnt_q   <= cnt_d;
         load_q  <= load_d;
         fmis_q  <= fmis_d;
         fbus_q  <= fbus_d;
      end
   end

   // Bus outputs decode straight from the state register, so reset drops
   // mem_req without waiting for a clock edge.
   assign mem_req        = (state_q == ST_REQ);
   assign mem_we         = mem_req & al_store;
   assign mem_addr       = mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign mem_wdata      = mem_we ? al_wdata : '0;
   assign mem_wstrb      = mem_req ? al_wstrb : 4'b0000;
   assign busy           = !in_idle;
   assign done           = (state_q == ST_DONE);
   assign load_data      = load_q;
   assign fault_misalign = fmis_q;
   assign fault_bus      = fbus_q;

endmodule

// File: tb/tb_core_lsu.sv
module tb_core_lsu;
   import core_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  flags;
   logic [31:0] addr, store_data;
   logic        busy, done;
   logic [31:0] load_data;
   logic        fault_misalign, fault_bus;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   core_lsu #(.XLEN(32), .TIMEOUT_CYC(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .i_lb           (flags[0]),
      .i_lh           (flags[1]),
      .i_lw           (flags[2]),
      .i_lbu          (flags[3]),
      .i_lhu          (flags[4]),
      .i_sb           (flags[5]),
      .i_sh           (flags[6]),
      .i_sw           (flags[7]),
      .addr           (addr),
      .store_data     (store_data),
      .busy           (busy),
      .done           (done),
      .load_data      (load_data),
      .fault_misalign (fault_misalign),
      .fault_bus      (fault_bus),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_wstrb      (mem_wstrb),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [31:0] rdata;
      int          ack_dly;   // REQ cycles without ack before the ack cycle
      int          e_cyc;     // cycle index (start = 0) in which done is seen
      logic        e_mis;
      logic        e_bus;
      logic        e_req;
      logic [31:0] e_addr;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic [31:0] e_load;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] sd,
                               input logic [31:0] rd, input int dly, input int cyc,
                               input logic mis, input logic bus, input logic req,
                               input logic [31:0] ea, input logic [3:0] es,
                               input logic [31:0] ew, input logic [31:0] el);
      vec_t v;
      v.op = op; v.addr = a; v.sd = sd; v.rdata = rd; v.ack_dly = dly; v.e_cyc = cyc;
      v.e_mis = mis; v.e_bus = bus; v.e_req = req; v.e_addr = ea; v.e_strb = es;
      v.e_wdata = ew; v.e_load = el;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] sd);
      @(negedge clk);
      flags      = 8'b1 << op;
      start      = 1'b1;
      addr       = a;
      store_data = sd;
      @(negedge clk);
      start = 1'b0;
      flags = 8'h00;
   endtask

   task automatic run_vec(input int idx);
      vec_t        v;
      int          done_cyc, nreq;
      logic        saw, unstable, g_mis, g_bus, g_req_done, f_we;
      logic [31:0] g_load, f_addr, f_wdata;
      logic [3:0]  f_strb;
      string       p;
      v = vecs[idx];
      p = $sformatf("v%0d", idx);
      done_cyc = -1; nreq = 0; saw = 0; unstable = 0;
      g_mis = 0; g_bus = 0; g_req_done = 0; g_load = '0;
      f_addr = '0; f_wdata = '0; f_strb = '0; f_we = 0;
      issue(v.op, v.addr, v.sd);
      for (int c = 1; c <= 40; c++) begin
         if (done) begin
            done_cyc   = c;
            g_load     = load_data;
            g_mis      = fault_misalign;
            g_bus      = fault_bus;
            g_req_done = mem_req;
            break;
         end
         if (mem_req) begin
            if (!saw) begin
               saw = 1; f_addr = mem_addr; f_strb = mem_wstrb; f_wdata = mem_wdata; f_we = mem_we;
            end else if (mem_addr !== f_addr || mem_wstrb !== f_strb ||
                         mem_wdata !== f_wdata || mem_we !== f_we) begin
               unstable = 1;
            end
            nreq++;
            if (nreq > v.ack_dly) begin
               mem_ack   = 1'b1;
               mem_rdata = v.rdata;
            end
         end
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = 32'hCCCC_CCCC;
      end
      chk({p, ".done_cyc"}, 32'(done_cyc), 32'(v.e_cyc));
      chk({p, ".misalign"}, {31'h0, g_mis}, {31'h0, v.e_mis});
      chk({p, ".fault_bus"}, {31'h0, g_bus}, {31'h0, v.e_bus});
      chk({p, ".load_data"}, g_load, v.e_load);
      chk({p, ".req_seen"}, {31'h0, saw}, {31'h0, v.e_req});
      chk({p, ".req_at_done"}, {31'h0, g_req_done}, 32'h0);
      if (v.e_req) begin
         chk({p, ".mem_addr"}, f_addr, v.e_addr);
         chk({p, ".wstrb"}, {28'h0, f_strb}, {28'h0, v.e_strb});
         chk({p, ".we"}, {31'h0, f_we}, {31'h0, op_is_store(lsu_op_e'(v.op))});
         chk({p, ".stable"}, {31'h0, unstable}, 32'h0);
         if (op_is_store(lsu_op_e'(v.op))) chk({p, ".wdata"}, f_wdata, v.e_wdata);
      end
      @(negedge clk);
      chk({p, ".busy_after"}, {31'h0, busy}, 32'h0);
      chk({p, ".req_after"}, {31'h0, mem_req}, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; flags = 8'h00; addr = '0; store_data = '0;
      mem_ack = 1'b0; mem_rdata = 32'hCCCC_CCCC;

      //            op      addr          sd            rdata         dly cyc mis bus req e_addr        strb     e_wdata       e_load
      vecs[0]  = mk(OP_SW,  32'h0000_0007, 32'h1234_5678, 32'h0,        0,  1,  1,  0,  0,  32'h0,        4'b0000, 32'h0,        32'h0);
      vecs[1]  = mk(OP_SW,  32'h0000_0004, 32'h0557_D0BE, 32'h0,        0,  2,  0,  0,  1,  32'h0000_0004, 4'b1111, 32'h0557_D0BE, 32'h0);
      vecs[2]  = mk(OP_SB,  32'h0000_0003, 32'h0000_00A5, 32'h0,        0,  2,  0,  0,  1,  32'h0,        4'b1000, 32'hA5A5_A5A5, 32'h0);
      vecs[3]  = mk(OP_LB,  32'h0000_0002, 32'h0,         32'h1280_3456, 3,  5,  0,  0,  1,  32'h0,        4'b0000, 32'h0,        32'hFFFF_FF80);
      vecs[4]  = mk(OP_LBU, 32'h0000_0002, 32'h0,         32'h1280_3456, 3,  5,  0,  0,  1,  32'h0,        4'b0000, 32'h0,        32'h0000_0080);
      vecs[5]  = mk(OP_LHU, 32'h0000_0002, 32'h0,         32'h8001_0000, 0,  2,  0,  0,  1,  32'h0,        4'b0000, 32'h0,        32'h0000_8001);
      vecs[6]  = mk(OP_LH,  32'h0000_0002, 32'h0,         32'h8001_0000, 0,  2,  0,  0,  1,  32'h0,        4'b0000, 32'h0,        32'hFFFF_8001);
      vecs[7]  = mk(OP_LH,  32'h0000_0001, 32'h0,         32'h0,        0,  1,  1,  0,  0,  32'h0,        4'b0000, 32'h0,        32'h0);
      vecs[8]  = mk(OP_SH,  32'h0000_0006, 32'h1234_BEEF, 32'h0,        1,  3,  0,  0,  1,  32'h0000_0004, 4'b1100, 32'hBEEF_BEEF, 32'h0);
      vecs[9]  = mk(OP_LW,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 15, 17, 0,  0,  1,  32'h0000_0010, 4'b0000, 32'h0,        32'hDEAD_BEEF);
      vecs[10] = mk(OP_LW,  32'h0000_0020, 32'h0,         32'h5555_5555, 255,17, 0,  1,  1,  32'h0000_0020, 4'b0000, 32'h0,        32'h0);
      vecs[11] = mk(OP_SB,  32'h0000_0101, 32'h1122_3344, 32'h0,        0,  2,  0,  0,  1,  32'h0000_0100, 4'b0010, 32'h4444_4444, 32'h0);
      vecs[12] = mk(OP_LB,  32'h0000_0000, 32'h0,         32'h0000_007F, 0,  2,  0,  0,  1,  32'h0,        4'b0000, 32'h0,        32'h0000_007F);
      vecs[13] = mk(OP_LBU, 32'h0000_0003, 32'h0,         32'hF000_0000, 2,  4,  0,  0,  1,  32'h0,        4'b0000, 32'h0,        32'h0000_00F0);
      vecs[14] = mk(OP_LW,  32'h0000_0002, 32'h0,         32'h0,        0,  1,  1,  0,  0,  32'h0,        4'b0000, 32'h0,        32'h0);
      vecs[15] = mk(OP_SH,  32'h0000_0008, 32'hCAFE_0123, 32'h0,        0,  2,  0,  0,  1,  32'h0000_0008, 4'b0011, 32'h0123_0123, 32'h0);

      // Reset values
      #12;
      chk("rst.busy", {31'h0, busy}, 32'h0);
      chk("rst.done", {31'h0, done}, 32'h0);
      chk("rst.mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst.mem_addr", mem_addr, 32'h0);
      chk("rst.wstrb", {28'h0, mem_wstrb}, 32'h0);
      chk("rst.load_data", load_data, 32'h0);
      chk("rst.faults", {30'h0, fault_misalign, fault_bus}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(i);

      // Illegal flag combinations and stray ack in IDLE are ignored
      @(negedge clk);
      flags = 8'b0000_0011; start = 1'b1; mem_ack = 1'b1;
      @(negedge clk);
      flags = 8'h00; start = 1'b1; mem_ack = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("ign.busy", {31'h0, busy}, 32'h0);
      chk("ign.req", {31'h0, mem_req}, 32'h0);
      @(negedge clk);
      chk("ign.done", {31'h0, done}, 32'h0);

      // Start while busy and in DONE is ignored; load_data held afterwards
      issue(OP_LW, 32'h0000_0040, 32'h0);
      chk("bz.req1", {31'h0, mem_req}, 32'h1);
      flags = 8'b1 << OP_SB; start = 1'b1; addr = 32'h0000_0001;
      mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'hCCCC_CCCC;
      chk("bz.done", {31'h0, done}, 32'h1);
      chk("bz.load", load_data, 32'h1111_2222);
      @(negedge clk);
      start = 1'b0; flags = 8'h00;
      chk("bz.idle", {31'h0, busy}, 32'h0);
      @(negedge clk);
      chk("bz.no_restart", {31'h0, busy | mem_req}, 32'h0);
      chk("bz.held", load_data, 32'h1111_2222);

      // Asynchronous reset in the middle of REQ
      issue(OP_LW, 32'h0000_0080, 32'h0);
      @(negedge clk);
      chk("ar.req_before", {31'h0, mem_req}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.req_drop", {31'h0, mem_req}, 32'h0);
      chk("ar.busy_drop", {31'h0, busy}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         logic seen;
         seen = 1'b0;
         for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || mem_req) seen = 1'b1;
         end
         chk("ar.no_done", {31'h0, seen}, 32'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
- Load/store unit directly downstream of core_alu.
- Takes the ALU RESULT (RS1+IMM) as the effective address and RS2 as the store data for LB/LH/LW/LBU/LHU/SB/SH/SW.
- Runs one data-memory transaction over a req/ack handshake and returns sign- or zero-extended load data to writeback.
- Detects misaligned accesses and bus timeouts.

Parameters:
- XLEN, 32, datapath/address width (only 32 supported).
- TIMEOUT_CYC, 16, max cycles in REQ without mem_ack before bus fault (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- start  in  1  one-cycle pulse: memory op issued from execute.
- i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw  in  1 each  one-hot op flags, sampled with start.
- addr  in  32  effective address (ALU RESULT).
- store_data  in  32  RS2 value.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  formatted load result; valid with done, held until next accepted start.
- fault_misalign  out  1  valid with done.
- fault_bus  out  1  valid with done.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, [1:0] = 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables; 0 on reads.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle transfer acknowledge.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Asserting rst_n low mid-transaction drops mem_req immediately, with no done pulse.
- States: IDLE, REQ, DONE.
- IDLE:
  - start is accepted only if exactly one op flag is high; otherwise it is ignored (no busy, no done).
  - On accept, latch op, addr and store_data; clear both fault outputs.
  - Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) goes to DONE with fault_misalign=1, mem_req never asserted, load_data=0.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1. mem_we, mem_addr, mem_wdata and mem_wstrb stay stable until ack.
  - Counter increments each REQ cycle.
  - mem_ack=1: capture formatted mem_rdata (loads), go to DONE.
  - Counter reaches TIMEOUT_CYC with no ack: fault_bus=1, load_data=0, go to DONE.
  - If ack arrives in the same cycle the counter hits the limit, ack wins.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Latency: start at cycle 0 gives mem_req in cycle 1. Ack in cycle 1 gives done in cycle 2 (minimum 2 cycles). A misaligned op gives done in cycle 1.
- start while busy or in DONE is ignored. mem_ack outside REQ is ignored.
- Store formatting:
  - SB: wdata={4{sd[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=sd, wstrb=4'b1111.
- Load formatting: byte/half selected by addr[1:0]/addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.

Decomposition:
- Shared package/include core_lsu_pkg: state encoding, op encoding (3-bit op index derived from the one-hot flags), TIMEOUT_CYC default.
- One combinational sub-module core_lsu_align: misalign detect, wstrb/wdata generation, load extract/extend.
- The FSM, counter and handshake stay in core_lsu.

Test Plan:
- SW addr=0x0000_0007 -> done at cycle 1, fault_misalign=1, mem_req never high.
- SW addr=0x0000_0004, store_data=0x0557_D0BE, ack in first REQ cycle -> mem_addr=0x4, wstrb=1111, wdata=0x0557_D0BE, done at cycle 2.
- SB addr=0x0000_0003, store_data=0x0000_00A5 -> wstrb=1000, wdata=0xA5A5_A5A5.
- LB addr=0x0000_0002, rdata=0x1280_3456, ack after 3 REQ cycles -> load_data=0xFFFF_FF80, done at cycle 5. The same access with LBU -> 0x0000_0080.
- LHU addr=0x0000_0002, rdata=0x8001_0000 -> 0x0000_8001. LH -> 0xFFFF_8001.
- LW with mem_ack never asserted, TIMEOUT_CYC=16 -> done after 16 REQ cycles, fault_bus=1, mem_req low afterwards. A further LW with rst_n pulsed low mid-REQ -> mem_req drops asynchronously, no done.
